// File: rtl/queue_pkg.sv
// Shared width helpers and lane-count types for the multi-lane queue family.
package queue_pkg;

  localparam int LANE_CNT_W = 5;

  // Holds accepted-lane counts, prefix counts and effective pops (up to 31 lanes).
  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/enq_compact.sv
// Prefix count of accepted enqueue lanes, used to pack accepted lanes into
// consecutive slots starting at the tail.
module enq_compact
  import queue_pkg::*;
#(
  parameter int NUM_ENQ = 4
) (
  input  logic [NUM_ENQ-1:0] accept,
  output lane_cnt_t          prefix [NUM_ENQ],
  output lane_cnt_t          total
);

  lane_cnt_t run;

  always_comb begin
    run = '0;
    for (int i = 0; i < NUM_ENQ; i++) begin
      prefix[i] = run;
      run = run + lane_cnt_t'(accept[i]);
    end
    total = run;
  end

endmodule

// File: rtl/multi_port_queue.sv
// Multi-lane circular queue: NUM_ENQ compacted pushes and up to NUM_DEQ pops per cycle.
// Optional registered almost_full output enabled by MULTI_PORT_QUEUE_ALMOST_FULL_EN.
module multi_port_queue
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 16,
  parameter int NUM_ENQ     = 4,
  parameter int NUM_DEQ     = 2,
  parameter int AF_THRESH   = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_ENQ-1:0]                 enq_valid,
  input  logic [NUM_ENQ*DATA_WIDTH-1:0]      enq_data,
  output logic [NUM_ENQ-1:0]                 enq_ready,
  output logic [NUM_DEQ-1:0]                 deq_valid,
  output logic [NUM_DEQ*DATA_WIDTH-1:0]      deq_data,
  input  logic [$clog2(NUM_DEQ+1)-1:0]       deq_pop,
`ifdef MULTI_PORT_QUEUE_ALMOST_FULL_EN
  output logic                               almost_full,
`endif
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = ptr_width(QUEUE_DEPTH);
  localparam int CNT_W = cnt_width(QUEUE_DEPTH);

  if (QUEUE_DEPTH < NUM_ENQ || QUEUE_DEPTH < NUM_DEQ || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("multi_port_queue: QUEUE_DEPTH must be a power of two >= NUM_ENQ and NUM_DEQ");
  end
  if (AF_THRESH > QUEUE_DEPTH) begin : g_bad_thresh
    $error("multi_port_queue: AF_THRESH is unreachable");
  end

  logic [DATA_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      occupancy_q, occupancy_d;

  logic [CNT_W-1:0]      free;
  logic [NUM_ENQ-1:0]    accept;
  lane_cnt_t             prefix [NUM_ENQ];
  lane_cnt_t             acc_cnt;
  lane_cnt_t             eff_pop;
  logic [PTR_W-1:0]      wr_idx [NUM_ENQ];
  logic [PTR_W-1:0]      rd_idx [NUM_DEQ];

  // Space comes from registered occupancy only, so a same-cycle pop never frees a slot.
  always_comb begin
    free = CNT_W'(QUEUE_DEPTH) - occupancy_q;
    for (int i = 0; i < NUM_ENQ; i++) begin
      enq_ready[i] = free > CNT_W'(i);
    end
    accept = enq_valid & enq_ready;
  end

  enq_compact #(
    .NUM_ENQ (NUM_ENQ)
  ) u_enq_compact (
    .accept (accept),
    .prefix (prefix),
    .total  (acc_cnt)
  );

  always_comb begin
    eff_pop = lane_cnt_t'(deq_pop);
    if (eff_pop > lane_cnt_t'(NUM_DEQ)) eff_pop = lane_cnt_t'(NUM_DEQ);
    if (CNT_W'(eff_pop) > occupancy_q) eff_pop = lane_cnt_t'(occupancy_q);
  end

  always_comb begin
    for (int i = 0; i < NUM_ENQ; i++) begin
      wr_idx[i] = tail_q + PTR_W'(prefix[i]);
    end
    mem_d = mem_q;
    if (!flush) begin
      for (int i = 0; i < NUM_ENQ; i++) begin
        if (accept[i]) mem_d[wr_idx[i]] = enq_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    head_d      = head_q + PTR_W'(eff_pop);
    tail_d      = tail_q + PTR_W'(acc_cnt);
    occupancy_d = occupancy_q + CNT_W'(acc_cnt) - CNT_W'(eff_pop);
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      occupancy_d = '0;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_DEQ; j++) begin
      rd_idx[j]                            = head_q + PTR_W'(j);
      deq_valid[j]                         = occupancy_q > CNT_W'(j);
      deq_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx[j]];
    end
  end

  assign occupancy = occupancy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occupancy_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occupancy_q <= occupancy_d;
    end
  end

  // Storage is deliberately unreset; contents are only observed behind deq_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef MULTI_PORT_QUEUE_ALMOST_FULL_EN
  logic af_q, af_d;

  assign af_d        = occupancy_d >= CNT_W'(AF_THRESH);
  assign almost_full = af_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) af_q <= 1'b0;
    else      af_q <= af_d;
  end
`endif

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed vector bench for multi_port_queue (8-bit, depth 8, 4 enqueue / 2 dequeue lanes).
module tb_multi_port_queue;

  localparam int DW = 8;
  localparam int QD = 8;
  localparam int NE = 4;
  localparam int ND = 2;
  localparam int AF = 6;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [NE-1:0] enq_valid;
  logic [NE*DW-1:0] enq_data;
  logic [NE-1:0] enq_ready;
  logic [ND-1:0] deq_valid;
  logic [ND*DW-1:0] deq_data;
  logic [1:0]    deq_pop;
  logic [3:0]    occupancy;
`ifdef MULTI_PORT_QUEUE_ALMOST_FULL_EN
  logic          almost_full;
`endif

  multi_port_queue #(
    .DATA_WIDTH  (DW),
    .QUEUE_DEPTH (QD),
    .NUM_ENQ     (NE),
    .NUM_DEQ     (ND),
    .AF_THRESH   (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_data    (enq_data),
    .enq_ready   (enq_ready),
    .deq_valid   (deq_valid),
    .deq_data    (deq_data),
    .deq_pop     (deq_pop),
`ifdef MULTI_PORT_QUEUE_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [1:0]  pop;
    logic [3:0]  er;
    logic [1:0]  dv;
    logic [3:0]  occ;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;

  localparam int NV = 26;
  vec_t vec [NV];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic fl, input logic [3:0] ev, input logic [31:0] ed,
                              input logic [1:0] pop, input logic [3:0] er, input logic [1:0] dv,
                              input logic [3:0] occ, input logic [7:0] d0, input logic [7:0] d1);
    vec_t v;
    v.fl = fl; v.ev = ev; v.ed = ed; v.pop = pop;
    v.er = er; v.dv = dv; v.occ = occ; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; enq_valid = '0; enq_data = '0; deq_pop = '0;
  endtask

  initial begin
    // Inputs applied this cycle, then outputs expected before the following edge.
    //            fl  ev       ed            pop  er       dv     occ d0     d1
    vec[0]  = mk(0, 4'b0000, 32'h0,         0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[1]  = mk(0, 4'b1010, 32'h3300_1100, 0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[2]  = mk(0, 4'b0000, 32'h0,         0, 4'b1111, 2'b11, 2, 8'h11, 8'h33);
    vec[3]  = mk(0, 4'b1111, 32'h4443_4241, 0, 4'b1111, 2'b11, 2, 8'h11, 8'h33);
    vec[4]  = mk(0, 4'b1111, 32'h5453_5251, 2, 4'b0011, 2'b11, 6, 8'h11, 8'h33);
    vec[5]  = mk(0, 4'b0000, 32'h0,         2, 4'b0011, 2'b11, 6, 8'h41, 8'h42);
    vec[6]  = mk(0, 4'b0000, 32'h0,         2, 4'b1111, 2'b11, 4, 8'h43, 8'h44);
    vec[7]  = mk(0, 4'b0000, 32'h0,         2, 4'b1111, 2'b11, 2, 8'h51, 8'h52);
    vec[8]  = mk(0, 4'b1111, 32'h6463_6261, 0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[9]  = mk(0, 4'b0011, 32'h0000_7271, 2, 4'b1111, 2'b11, 4, 8'h61, 8'h62);
    vec[10] = mk(0, 4'b0000, 32'h0,         2, 4'b1111, 2'b11, 4, 8'h63, 8'h64);
    vec[11] = mk(0, 4'b0000, 32'h0,         3, 4'b1111, 2'b11, 2, 8'h71, 8'h72);
    vec[12] = mk(0, 4'b1111, 32'hD4C3_B2A1, 0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[13] = mk(0, 4'b0000, 32'h0,         2, 4'b1111, 2'b11, 4, 8'hA1, 8'hB2);
    vec[14] = mk(0, 4'b0100, 32'h00E5_0000, 2, 4'b1111, 2'b11, 2, 8'hC3, 8'hD4);
    vec[15] = mk(0, 4'b0000, 32'h0,         2, 4'b1111, 2'b01, 1, 8'hE5, 8'h00);
    vec[16] = mk(0, 4'b0001, 32'h0000_00F6, 0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[17] = mk(0, 4'b1111, 32'h8483_8281, 0, 4'b1111, 2'b01, 1, 8'hF6, 8'h00);
    vec[18] = mk(1, 4'b1111, 32'h9999_9999, 1, 4'b0111, 2'b11, 5, 8'hF6, 8'h81);
    vec[19] = mk(0, 4'b0000, 32'h0,         0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[20] = mk(0, 4'b1111, 32'hA4A3_A2A1, 0, 4'b1111, 2'b00, 0, 8'h00, 8'h00);
    vec[21] = mk(0, 4'b1111, 32'hB4B3_B2B1, 0, 4'b1111, 2'b11, 4, 8'hA1, 8'hA2);
    vec[22] = mk(0, 4'b1111, 32'hC4C3_C2C1, 2, 4'b0000, 2'b11, 8, 8'hA1, 8'hA2);
    vec[23] = mk(0, 4'b1111, 32'hD4D3_D2D1, 2, 4'b0011, 2'b11, 6, 8'hA3, 8'hA4);
    vec[24] = mk(0, 4'b0001, 32'h0000_00E7, 0, 4'b0011, 2'b11, 6, 8'hB1, 8'hB2);
    vec[25] = mk(0, 4'b0000, 32'h0,         0, 4'b0001, 2'b11, 7, 8'hB1, 8'hB2);

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_dv",    32'(deq_valid), 32'd0);
    chk("rst_ready", 32'(enq_ready), 32'hF);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      flush = vec[i].fl; enq_valid = vec[i].ev; enq_data = vec[i].ed; deq_pop = vec[i].pop;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(enq_ready), 32'(vec[i].er));
      chk($sformatf("v%0d_dv", i),    32'(deq_valid), 32'(vec[i].dv));
      chk($sformatf("v%0d_occ", i),   32'(occupancy), 32'(vec[i].occ));
      if (vec[i].dv[0]) chk($sformatf("v%0d_d0", i), 32'(deq_data[7:0]),  32'(vec[i].d0));
      if (vec[i].dv[1]) chk($sformatf("v%0d_d1", i), 32'(deq_data[15:8]), 32'(vec[i].d1));
`ifdef MULTI_PORT_QUEUE_ALMOST_FULL_EN
      chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(vec[i].occ >= 4'(AF)));
`endif
    end

    // Async reset between edges with 7 entries held, while an enqueue is pending.
    @(negedge clk);
    idle_inputs();
    enq_valid = 4'b0001; enq_data = 32'h0000_00EE; deq_pop = 2'd1;
    #1;
    chk("pre_arst_occ", 32'(occupancy), 32'd7);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_occ",   32'(occupancy), 32'd0);
    chk("arst_dv",    32'(deq_valid), 32'd0);
    chk("arst_ready", 32'(enq_ready), 32'hF);
`ifdef MULTI_PORT_QUEUE_ALMOST_FULL_EN
    chk("arst_af", 32'(almost_full), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("arst_hold_occ", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_dv",  32'(deq_valid), 32'd0);

    // Pointers restart at 0 after reset: one push then one read-back.
    enq_valid = 4'b0010; enq_data = 32'h0000_5A00;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_push_occ", 32'(occupancy), 32'd1);
    chk("post_rst_push_d0",  32'(deq_data[7:0]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
